// File: rtl/cdc_fifo_write_arbiter_if.sv
// Write-side bundle between producer engines, the arbiter and the cdc_fifo write port.
// Port p's beat occupies in_data[p], i.e. bits [p*DATA_WIDTH +: DATA_WIDTH].
interface cdc_fifo_write_arbiter_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]                 in_valid;
    logic [NUM_PORTS-1:0]                 in_last;
    logic [NUM_PORTS-1:0]                 in_ready;
    logic [DATA_WIDTH-1:0]                fifo_data;
    logic                                 fifo_req;
    logic                                 fifo_full;
    logic                                 grant_valid;
    logic [ID_WIDTH-1:0]                  grant_id;

    modport master (
        output in_data, in_valid, in_last, fifo_full,
        input  in_ready, fifo_data, fifo_req, grant_valid, grant_id
    );

    modport slave (
        input  in_data, in_valid, in_last, fifo_full,
        output in_ready, fifo_data, fifo_req, grant_valid, grant_id
    );
endinterface

// File: rtl/cdc_fifo_write_arbiter.sv
// Packet-locked round-robin arbiter sharing one cdc_fifo write port between NUM_PORTS producers.
// A grant lasts until the holder's last beat or MAX_BURST beats; each grant costs one idle cycle.
module cdc_fifo_write_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    cdc_fifo_write_arbiter_if.slave  bus
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] gid_q, gid_d, ptr_q, ptr_d, pick, idx;
    logic                gv_q, gv_d, found, busy, xfer, rel;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Search starts just after the last holder so every port gets a turn.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = ID_WIDTH'((int'(ptr_q) + i) % NUM_PORTS);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Beat moves exactly when the cdc_fifo writes it (req && ~full).
    assign busy = (state_q == BUSY);
    assign xfer = busy && bus.in_valid[gid_q] && !bus.fifo_full;
    assign rel  = xfer && (bus.in_last[gid_q] || cnt_q == CNT_W'(MAX_BURST - 1));

    assign bus.fifo_data   = busy ? bus.in_data[gid_q] : '0;
    assign bus.fifo_req    = busy && bus.in_valid[gid_q];
    assign bus.grant_valid = gv_q;
    assign bus.grant_id    = gid_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdy
        assign bus.in_ready[p] = busy && (gid_q == ID_WIDTH'(p)) && !bus.fifo_full;
    end

    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        gv_d    = gv_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gid_d   = pick;
                    gv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    state_d = IDLE;
                    gv_d    = 1'b0;
                    ptr_d   = gid_q;
                    cnt_d   = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gid_q   <= '0;
            gv_q    <= 1'b0;
            ptr_q   <= ID_WIDTH'(NUM_PORTS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            gv_q    <= gv_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench: per-cycle vector table plus two traffic sequences (rotation, MAX_BURST split).
module tb_cdc_fifo_write_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdc_fifo_write_arbiter_if #(.NUM_PORTS(4), .ID_WIDTH(2), .DATA_WIDTH(8)) bus ();

    cdc_fifo_write_arbiter #(.NUM_PORTS(4), .ID_WIDTH(2), .DATA_WIDTH(8), .MAX_BURST(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic        full;
        logic [3:0]  e_rdy;
        logic        e_req;
        logic [7:0]  e_dat;
        logic        e_gv;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_err = 0;

    int   tot[4];
    int   pl[4];
    int   rdy_cnt[4];
    int   lg_gid[$];
    int   lg_dat[$];

    task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                       input logic [31:0] dat, input logic full, input logic [3:0] e_rdy,
                       input logic e_req, input logic [7:0] e_dat, input logic e_gv,
                       input logic [1:0] e_gid);
        vec_t v;
        v.rst = rst; v.vld = vld; v.lst = lst; v.dat = dat; v.full = full;
        v.e_rdy = e_rdy; v.e_req = e_req; v.e_dat = e_dat; v.e_gv = e_gv; v.e_gid = e_gid;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.fifo_full = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Behavioural producers: port p sends tot[p] beats in packets of pl[p], data = {p, beat index}.
    task automatic run_traffic(input int ncyc);
        int         sent[4];
        logic [3:0] acc;
        for (int p = 0; p < 4; p++) begin
            sent[p] = 0;
            rdy_cnt[p] = 0;
        end
        lg_gid.delete();
        lg_dat.delete();
        for (int c = 0; c < ncyc; c++) begin
            for (int p = 0; p < 4; p++) begin
                bus.in_valid[p] = (sent[p] < tot[p]);
                bus.in_data[p]  = 8'((p << 6) | sent[p]);
                bus.in_last[p]  = ((sent[p] % pl[p]) == pl[p] - 1) || (sent[p] == tot[p] - 1);
            end
            bus.fifo_full = 1'b0;
            @(negedge clk);
            if (bus.fifo_req && !bus.fifo_full) begin
                lg_gid.push_back(int'(bus.grant_id));
                lg_dat.push_back(int'(bus.fifo_data));
            end
            for (int p = 0; p < 4; p++) begin
                if (bus.in_ready[p]) rdy_cnt[p]++;
                acc[p] = bus.in_valid[p] && bus.in_ready[p];
            end
            @(posedge clk); #1;
            for (int p = 0; p < 4; p++) if (acc[p]) sent[p]++;
        end
        idle_inputs();
    endtask

    initial begin
        // ports 0 and 2, three-beat packets
        add(1, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b0101, 4'b0000, 32'h00200010, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b0101, 4'b0000, 32'h00200010, 0, 4'b0001, 1, 8'h10, 1, 2'd0);
        add(0, 4'b0101, 4'b0000, 32'h00200011, 0, 4'b0001, 1, 8'h11, 1, 2'd0);
        add(0, 4'b0101, 4'b0001, 32'h00200012, 0, 4'b0001, 1, 8'h12, 1, 2'd0);
        add(0, 4'b0100, 4'b0000, 32'h00200000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b0100, 4'b0000, 32'h00200000, 0, 4'b0100, 1, 8'h20, 1, 2'd2);
        add(0, 4'b0100, 4'b0000, 32'h00210000, 0, 4'b0100, 1, 8'h21, 1, 2'd2);
        add(0, 4'b0100, 4'b0100, 32'h00220000, 0, 4'b0100, 1, 8'h22, 1, 2'd2);
        add(0, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 2'd2);
        // port 1 with fifo_full held for 5 cycles mid-packet
        add(0, 4'b0010, 4'b0000, 32'h00003000, 0, 4'b0000, 0, 8'h00, 0, 2'd2);
        add(0, 4'b0010, 4'b0000, 32'h00003000, 0, 4'b0010, 1, 8'h30, 1, 2'd1);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0010, 4'b0000, 32'h00003100, 1, 4'b0000, 1, 8'h31, 1, 2'd1);
        add(0, 4'b0010, 4'b0000, 32'h00003100, 0, 4'b0010, 1, 8'h31, 1, 2'd1);
        add(0, 4'b0010, 4'b0010, 32'h00003200, 0, 4'b0010, 1, 8'h32, 1, 2'd1);
        add(0, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 2'd1);
        // port 3 holds while dropping valid; port 0 waits
        add(0, 4'b1001, 4'b0001, 32'h40000050, 0, 4'b0000, 0, 8'h00, 0, 2'd1);
        add(0, 4'b1001, 4'b0001, 32'h40000050, 0, 4'b1000, 1, 8'h40, 1, 2'd3);
        for (int i = 0; i < 3; i++)
            add(0, 4'b0001, 4'b0001, 32'h41000050, 0, 4'b1000, 0, 8'h41, 1, 2'd3);
        add(0, 4'b1001, 4'b1001, 32'h41000050, 0, 4'b1000, 1, 8'h41, 1, 2'd3);
        add(0, 4'b0001, 4'b0001, 32'h00000050, 0, 4'b0000, 0, 8'h00, 0, 2'd3);
        add(0, 4'b0001, 4'b0001, 32'h00000050, 0, 4'b0001, 1, 8'h50, 1, 2'd0);
        add(0, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 2'd0);
        // reset during beat 2 of a port-2 packet; port 0 then wins
        add(0, 4'b0100, 4'b0000, 32'h00600000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b0100, 4'b0000, 32'h00600000, 0, 4'b0100, 1, 8'h60, 1, 2'd2);
        add(0, 4'b0100, 4'b0000, 32'h00610000, 0, 4'b0100, 1, 8'h61, 1, 2'd2);
        add(1, 4'b0100, 4'b0000, 32'h00620000, 0, 4'b0100, 1, 8'h62, 1, 2'd2);
        add(0, 4'b0101, 4'b0001, 32'h00630070, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b0101, 4'b0001, 32'h00630070, 0, 4'b0001, 1, 8'h70, 1, 2'd0);
        add(0, 4'b0100, 4'b0000, 32'h00630000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b0100, 4'b0000, 32'h00630000, 0, 4'b0100, 1, 8'h63, 1, 2'd2);
        add(0, 4'b0100, 4'b0100, 32'h00640000, 0, 4'b0100, 1, 8'h64, 1, 2'd2);
        add(0, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 2'd2);
        // port 2 alone after reset is re-granted
        add(1, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 2'd2);
        add(0, 4'b0100, 4'b0100, 32'h00650000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
        add(0, 4'b0100, 4'b0100, 32'h00650000, 0, 4'b0100, 1, 8'h65, 1, 2'd2);
        add(0, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 8'h00, 0, 2'd2);

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        foreach (tv[k]) begin
            reset         = tv[k].rst;
            bus.in_valid  = tv[k].vld;
            bus.in_last   = tv[k].lst;
            bus.in_data   = tv[k].dat;
            bus.fifo_full = tv[k].full;
            @(negedge clk);
            chk($sformatf("vec%0d {rdy,req,dat,gv,gid}", k),
                32'({bus.in_ready, bus.fifo_req, bus.fifo_data, bus.grant_valid, bus.grant_id}),
                32'({tv[k].e_rdy, tv[k].e_req, tv[k].e_dat, tv[k].e_gv, tv[k].e_gid}));
            @(posedge clk); #1;
        end
        reset = 1'b0;

        // all four ports always valid, 1-beat packets: strict rotation
        do_reset();
        tot = '{2, 2, 2, 2};
        pl  = '{1, 1, 1, 1};
        run_traffic(24);
        chk("rot count", 32'(lg_gid.size()), 32'd8);
        for (int i = 0; i < 8 && i < lg_gid.size(); i++) begin
            chk($sformatf("rot gid%0d", i), 32'(lg_gid[i]), 32'(i % 4));
            chk($sformatf("rot dat%0d", i), 32'(lg_dat[i]), 32'(((i % 4) << 6) | (i / 4)));
        end
        for (int p = 0; p < 4; p++)
            chk($sformatf("rot rdy pulses p%0d", p), 32'(rdy_cnt[p]), 32'd2);

        // 40-beat packet on port 1 split at 16 beats, port 3 interleaved
        do_reset();
        tot = '{0, 40, 0, 2};
        pl  = '{1, 40, 1, 1};
        run_traffic(60);
        begin
            int eg[$];
            int ed[$];
            for (int b = 0;  b < 16; b++) begin eg.push_back(1); ed.push_back(8'h40 | b); end
            eg.push_back(3); ed.push_back(8'hC0);
            for (int b = 16; b < 32; b++) begin eg.push_back(1); ed.push_back(8'h40 | b); end
            eg.push_back(3); ed.push_back(8'hC1);
            for (int b = 32; b < 40; b++) begin eg.push_back(1); ed.push_back(8'h40 | b); end
            chk("burst count", 32'(lg_gid.size()), 32'(eg.size()));
            for (int i = 0; i < eg.size() && i < lg_gid.size(); i++)
                chk($sformatf("burst beat%0d {gid,dat}", i),
                    32'((lg_gid[i] << 8) | lg_dat[i]), 32'((eg[i] << 8) | ed[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
